// File: rtl/pixel_mem_arbiter.sv
// Time-slots one single-port double-buffered pixel BRAM between VGA scan-out reads
// and game-logic writes, with buffer swaps deferred to the vsync falling edge.
module pixel_mem_arbiter #(
  parameter int DATA_W = 4,
  parameter int FB_W   = 160,
  parameter int FB_H   = 120
) (
  input  logic              vclock_i,
  input  logic              reset_i,
  input  logic [9:0]        hcount_i,
  input  logic [9:0]        vcount_i,
  input  logic              blank_i,
  input  logic              vsync_i,
  input  logic              wr_req_i,
  input  logic [14:0]       wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_ack_o,
  input  logic              swap_req_i,
  output logic              swap_done_o,
  output logic              front_bank_o,
  output logic [15:0]       mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [DATA_W-1:0] pixel_out_o,
  output logic              blank_out_o
);

  localparam logic [14:0] FB_SIZE = 15'(FB_W * FB_H);

  typedef enum logic {RUN, PEND} state_t;

  state_t              state_q, state_d;
  logic [9:0]          hcount_q;
  logic                vsync_q;
  logic                front_q, front_d;
  logic                swap_done_q, swap_done_d;
  logic [15:0]         mem_addr_q, mem_addr_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                rd_vld_q;
  logic                blank_d1_q, blank_out_q;
  logic [DATA_W-1:0]   pixel_q, pixel_d;

  logic                disp;
  logic                grant;
  logic                vs_fall;
  logic [14:0]         v_row;
  logic [14:0]         rd_idx;
  logic                unused_vcount;

  assign unused_vcount = ^{vcount_i[9], vcount_i[1:0]};

  assign disp    = (hcount_i != hcount_q) && !blank_i;
  assign vs_fall = vsync_q && !vsync_i;
  assign v_row   = {8'd0, vcount_i[8:2]};
  // row * 160 as a shift-add: (v << 7) + (v << 5)
  assign rd_idx  = (v_row << 7) + (v_row << 5) + {7'd0, hcount_i[9:2]};
  assign grant   = !reset_i && !disp && wr_req_i && !swap_req_i && (state_q == RUN);

  always_comb begin
    state_d     = state_q;
    front_d     = front_q;
    swap_done_d = 1'b0;
    unique case (state_q)
      RUN: begin
        if (swap_req_i && vs_fall) begin
          front_d     = ~front_q;
          swap_done_d = 1'b1;
        end else if (swap_req_i) begin
          state_d = PEND;
        end
      end
      PEND: begin
        if (vs_fall) begin
          front_d     = ~front_q;
          swap_done_d = 1'b1;
          state_d     = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    if (disp) begin
      mem_addr_d = {front_q, rd_idx};
    end else if (grant) begin
      mem_addr_d  = {~front_q, wr_addr_i};
      mem_we_d    = (wr_addr_i < FB_SIZE);
      mem_wdata_d = wr_data_i;
    end
  end

  // mem_addr_q doubles as the BRAM address register, so read data is back the cycle after a DISP slot
  always_comb begin
    pixel_d = pixel_q;
    if (blank_d1_q)    pixel_d = '0;
    else if (rd_vld_q) pixel_d = mem_rdata_i;
  end

  always_ff @(posedge vclock_i) begin
    if (reset_i) begin
      state_q     <= RUN;
      hcount_q    <= '0;
      vsync_q     <= 1'b1;
      front_q     <= 1'b0;
      swap_done_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      rd_vld_q    <= 1'b0;
      blank_d1_q  <= 1'b1;
      blank_out_q <= 1'b1;
      pixel_q     <= '0;
    end else begin
      state_q     <= state_d;
      hcount_q    <= hcount_i;
      vsync_q     <= vsync_i;
      front_q     <= front_d;
      swap_done_q <= swap_done_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      rd_vld_q    <= disp;
      blank_d1_q  <= blank_i;
      blank_out_q <= blank_d1_q;
      pixel_q     <= pixel_d;
    end
  end

  assign wr_ack_o     = grant;
  assign swap_done_o  = swap_done_q;
  assign front_bank_o = front_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_we_o     = mem_we_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign pixel_out_o  = pixel_q;
  assign blank_out_o  = blank_out_q;

endmodule

// File: tb/tb_pixel_mem_arbiter.sv
// Directed bench for pixel_mem_arbiter on a shrunken raster; pixel/blank outputs are
// checked through a scoreboard fed from a reference copy of the frame memory.
module tb_pixel_mem_arbiter;

  localparam int H_ACT = 40, H_TOT = 52, V_ACT = 12, V_TOT = 16, VS0 = 13, VS1 = 15;
  localparam int BOUND = 4000;

  logic        vclock = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  hcount = '0, vcount = '0;
  logic        blank = 1'b1, vsync = 1'b1;
  logic        wr_req = 1'b0;
  logic [14:0] wr_addr = '0;
  logic [3:0]  wr_data = '0;
  logic        wr_ack, swap_req = 1'b0, swap_done, front_bank;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wdata, mem_rdata, pixel_out;
  logic        blank_out;

  pixel_mem_arbiter dut (
    .vclock_i(vclock), .reset_i(reset), .hcount_i(hcount), .vcount_i(vcount),
    .blank_i(blank), .vsync_i(vsync), .wr_req_i(wr_req), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .wr_ack_o(wr_ack), .swap_req_i(swap_req),
    .swap_done_o(swap_done), .front_bank_o(front_bank), .mem_addr_o(mem_addr),
    .mem_we_o(mem_we), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .pixel_out_o(pixel_out), .blank_out_o(blank_out)
  );

  always #5 vclock = ~vclock;

  // BRAM whose address register is the DUT's mem_addr register
  logic [3:0] mem     [65536];
  logic [3:0] ref_mem [65536];
  always @(posedge vclock) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  typedef struct { int due; logic [3:0] pix; logic blk; } sb_t;
  sb_t sb[$];

  int n_tests = 0, n_fail = 0, cyc = 0;
  int h = 0, v = V_ACT;
  logic ph = 1'b0;
  logic fb_exp = 1'b0, pend = 1'b0, sd_exp = 1'b0, vsq_m = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] idx(input int hh, input int vv);
    return 15'((vv / 4) * 160 + (hh / 4));
  endfunction

  always @(negedge vclock) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      sb_t e;
      e = sb.pop_front();
      if (e.due == cyc) begin
        chk("pixel_out", 32'(pixel_out), 32'(e.pix));
        chk("blank_out", 32'(blank_out), 32'(e.blk));
      end
    end
  end

  task automatic drive_timing();
    hcount = 10'(h);
    vcount = 10'(v);
    blank  = (h >= H_ACT) || (v >= V_ACT);
    vsync  = !(v >= VS0 && v < VS1);
  endtask

  task automatic tick();
    logic prev_disp, fall;
    logic [15:0] prev_addr;
    prev_disp = !ph && !blank && !reset;
    prev_addr = {fb_exp, idx(h, v)};
    if (reset) begin
      pend = 0; fb_exp = 0; sd_exp = 0; vsq_m = 1;
    end else begin
      fall = vsq_m && !vsync;
      if (fall && (pend || swap_req)) begin
        fb_exp = ~fb_exp; pend = 0; sd_exp = 1;
      end else begin
        sd_exp = 0;
        if (swap_req) pend = 1;
      end
      vsq_m = vsync;
    end
    @(posedge vclock);
    cyc++;
    #1;
    chk("front_bank", 32'(front_bank), 32'(fb_exp));
    chk("swap_done", 32'(swap_done), 32'(sd_exp));
    if (prev_disp) begin
      chk("disp mem_addr", 32'(mem_addr), 32'(prev_addr));
      chk("disp mem_we", 32'(mem_we), 32'd0);
    end
    swap_req = 1'b0;
    if (ph) begin
      ph = 1'b0;
      h++;
      if (h == H_TOT) begin
        h = 0;
        v = (v == V_TOT - 1) ? 0 : v + 1;
      end
    end else begin
      ph = 1'b1;
    end
    drive_timing();
    if (!reset) sb.push_back('{cyc + 2, blank ? 4'h0 : ref_mem[{fb_exp, idx(h, v)}], blank});
  endtask

  task automatic wait_pos(input int hh, input int vv);
    int n = 0;
    while (!(h == hh && v == vv && !ph) && n < BOUND) begin
      tick();
      n++;
    end
    chk("wait_pos bound", 32'(n < BOUND), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_req = 1'b1;
    sb.delete();
    repeat (3) tick();
    chk("rst wr_ack", 32'(wr_ack), 32'd0);
    chk("rst mem_addr", 32'(mem_addr), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst pixel_out", 32'(pixel_out), 32'd0);
    chk("rst blank_out", 32'(blank_out), 32'd1);
    reset = 1'b0;
    wr_req = 1'b0;
  endtask

  // Single write; checks ack latency and the registered BRAM command that follows
  task automatic wr_one(input logic [14:0] a, input logic [3:0] d, input int max_lat, input string tag);
    int n = 0;
    logic fb_at;
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    @(negedge vclock);
    while (!wr_ack && n < 3) begin
      tick();
      @(negedge vclock);
      n++;
    end
    chk({tag, " ack"}, 32'(wr_ack), 32'd1);
    chk({tag, " ack latency"}, 32'(n <= max_lat), 32'd1);
    fb_at = fb_exp;
    if (a < 15'd19200) ref_mem[{~fb_at, a}] = d;
    tick();
    wr_req = 1'b0;
    chk({tag, " mem_addr"}, 32'(mem_addr), 32'({~fb_at, a}));
    chk({tag, " mem_we"}, 32'(mem_we), 32'(a < 15'd19200));
    if (a < 15'd19200) chk({tag, " mem_wdata"}, 32'(mem_wdata), 32'(d));
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 65536; i++) begin
      ref_mem[i] = (i < 32768) ? 4'(i) : (4'(i) ^ 4'hF);
      mem[i] = ref_mem[i];
    end
    drive_timing();
    do_reset();

    // one full frame of bank 0
    wait_pos(0, V_ACT);
    wait_pos(0, V_ACT);

    // active-video write lands in the DISP phase, so it is acked one cycle later
    wait_pos(8, 4);
    wr_one(15'd161, 4'hA, 1, "active wr");
    chk("active wr addr 80A1", 32'(mem_addr), 32'h80A1);

    // back-to-back writes through vertical blank
    wait_pos(0, V_ACT);
    wr_req = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      logic fb_at;
      wr_addr = 15'(i);
      wr_data = 4'(i) ^ 4'h5;
      @(negedge vclock);
      chk("blank burst ack", 32'(wr_ack), 32'd1);
      if (wr_ack) cnt++;
      fb_at = fb_exp;
      ref_mem[{~fb_at, 15'(i)}] = 4'(i) ^ 4'h5;
      tick();
      chk("burst mem_addr", 32'(mem_addr), 32'({~fb_at, 15'(i)}));
      chk("burst mem_we", 32'(mem_we), 32'd1);
      chk("burst mem_wdata", 32'(mem_wdata), 32'(4'(i) ^ 4'h5));
    end
    wr_req = 1'b0;
    chk("burst ack count", 32'(cnt), 32'd100);

    wr_one(15'd19200, 4'h3, 0, "overrange wr");

    // mid-frame swap stalls the writer until swap_done
    wait_pos(4, 2);
    swap_req = 1'b1;
    wr_req = 1'b1; wr_addr = 15'd5; wr_data = 4'h9;
    cnt = 0;
    @(negedge vclock);
    while (!swap_done && cnt < BOUND) begin
      chk("stalled wr_ack", 32'(wr_ack), 32'd0);
      tick();
      @(negedge vclock);
      cnt++;
    end
    chk("swap_done seen", 32'(swap_done), 32'd1);
    chk("front after swap", 32'(front_bank), 32'd1);
    chk("ack after swap", 32'(wr_ack), 32'd1);
    ref_mem[{1'b0, 15'd5}] = 4'h9;
    tick();
    wr_req = 1'b0;
    chk("post-swap wr bank0", 32'(mem_addr), 32'h0005);
    chk("post-swap mem_we", 32'(mem_we), 32'd1);

    // bank 1 frame shows the earlier writes
    wait_pos(0, V_ACT);

    // swap_req coincident with the vsync falling edge
    wait_pos(0, VS0);
    swap_req = 1'b1;
    tick();
    chk("coincident swap_done", 32'(swap_done), 32'd1);
    chk("coincident front", 32'(front_bank), 32'd0);

    // two requests while pending give one swap
    wait_pos(4, 2);
    swap_req = 1'b1;
    repeat (3) tick();
    swap_req = 1'b1;
    cnt = 0;
    for (int i = 0; i < 1700; i++) begin
      tick();
      if (swap_done) cnt++;
    end
    chk("merged swap count", 32'(cnt), 32'd1);
    chk("merged front", 32'(front_bank), 32'd1);

    // reset while pending cancels the swap
    wait_pos(4, 2);
    swap_req = 1'b1;
    tick();
    wait_pos(0, V_ACT);
    do_reset();
    cnt = 0;
    for (int i = 0; i < 1700; i++) begin
      tick();
      if (swap_done) cnt++;
    end
    chk("no swap after reset", 32'(cnt), 32'd0);
    chk("front after reset", 32'(front_bank), 32'd0);

    repeat (4) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
